add8_word_sequencer: RTL and testbench

Byte-serial multi-word adder controller that sequences a single 8-bit ripple adder datapath (ports in1, in2, cin, sum, cout) over NBYTES passes to produce an 8*NBYTES-bit sum. It accepts an operand pair with a start/ready handshake, feeds one byte per cycle LSB-first with carry chaining through a carry register, and reports result, carry-out and signed overflow with a one-cycle done pulse. It sits between a wide-operand requester and the shared byte adder, trading latency for area.

---
 rtl/add8_word_sequencer.sv | 150 +++++++++++++++
 tb/tb_add8_word_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/add8_word_sequencer.sv
// add8_word_sequencer: byte-serial multi-word adder controller.
// Feeds one 8-bit ripple adder one byte per cycle, LSB first, chaining the carry
// through a register, and produces an 8*NBYTES-bit result with carry-out and
// signed overflow.
// Optional feature macro: ADD8_SUB_EN adds the op port and the subtract path
// (op=1 inverts B and forces the byte-0 carry-in to 1).
module add8_word_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef ADD8_SUB_EN
    input  logic                  op,
`endif
    output logic                  ready,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_d;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;        // already holds b_eff
    logic [W-1:0]    result_q;
    logic            carry_q;
    logic            ready_q;
    logic            done_q;
    logic            cout_q;
    logic            ovf_q;

    // Operand conditioning applied at capture time
    logic [W-1:0]    b_eff_d;
    logic            cin_eff_d;
`ifdef ADD8_SUB_EN
    assign b_eff_d   = op ? ~b : b;
    assign cin_eff_d = op | cin;
`else
    assign b_eff_d   = b;
    assign cin_eff_d = cin;
`endif

    // Byte views of the captured operands, selected by the running index
    logic [7:0] a_byte [NBYTES];
    logic [7:0] b_byte [NBYTES];
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign a_byte[gi] = a_q[8*gi +: 8];
        assign b_byte[gi] = b_q[8*gi +: 8];
    end

    // Shared 8-bit ripple adder datapath
    logic [7:0] add_in1;
    logic [7:0] add_in2;
    logic [7:0] add_sum;
    logic [8:0] add_carry;
    logic       add_cout;

    assign add_in1      = a_byte[idx_q];
    assign add_in2      = b_byte[idx_q];
    assign add_carry[0] = carry_q;

    for (genvar gi = 0; gi < 8; gi++) begin : g_fa
        assign add_sum[gi]     = add_in1[gi] ^ add_in2[gi] ^ add_carry[gi];
        assign add_carry[gi+1] = (add_in1[gi] & add_in2[gi]) |
                                 (add_carry[gi] & (add_in1[gi] ^ add_in2[gi]));
    end
    assign add_cout = add_carry[8];

    // Next index and overflow of the final byte
    logic ovf_d;
    assign idx_d = idx_q + IW'(1);
    assign ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);

    // Control FSM with registered outputs; DONE accepts a new start like IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_eff_d;
                        carry_q <= cin_eff_d;
                        idx_q   <= '0;
                        state_q <= S_BUSY;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx_q == IW'(i)) begin
                            result_q[8*i +: 8] <= add_sum;
                        end
                    end
                    carry_q <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= add_cout;
                        ovf_q   <= ovf_d;
                        idx_q   <= '0;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q   <= idx_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_add8_word_sequencer.sv
// Self-checking bench for add8_word_sequencer (NBYTES=4): constant vector table,
// randomized operations against an arithmetic reference model, and hand-written
// protocol sequences (held start, back-to-back, asynchronous abort).
module tb_add8_word_sequencer;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          op_s;
    logic          ready;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    add8_word_sequencer #(.NBYTES(NB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
`ifdef ADD8_SUB_EN
        .op     (op_s),
`endif
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic         vo;
        logic [W-1:0] er;
        logic         ec;
        logic         ev;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mc, input logic mo,
                                  output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] full;
        longint     sa, sb, s;
        longint     maxs, mins;
        maxs = (longint'(1) <<< (W-1)) - 1;
        mins = -(longint'(1) <<< (W-1));
        sa = $signed(ma);
        sb = $signed(mb);
        if (mo) begin
            r  = ma - mb;
            co = (ma >= mb);
            s  = sa - sb;
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
            r  = full[W-1:0];
            co = full[W];
            s  = sa + sb + longint'(mc);
        end
        ov = (s > maxs) || (s < mins);
    endfunction

    // One full operation: start, per-cycle BUSY checks, latency and outputs
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic to,
                          input logic [W-1:0] er, input logic ec, input logic ev);
        int k;
        k = 0;
        while (!ready && k < 4*NB) begin
            @(posedge clk); #1; k++;
        end
        check("ready_before_start", ready, 1);
        a = ta; b = tb_v; cin = tc; op_s = to; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        check("busy_ready", ready, 0);
        while (k < 3*NB) begin
            @(posedge clk); #1; k++;
            if (done) break;
            check("busy_ready", ready, 0);
        end
        check("latency", k, NB);
        check("result", result, er);
        check("cout", cout, ec);
        check("ovf", ovf, ev);
        check("done_ready", ready, 1);
        $display("op a=%h b=%h cin=%0d op=%0d -> result=%h cout=%0d ovf=%0d",
                 ta, tb_v, tc, to, result, cout, ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, er;
        logic         rc, ro, ec, ev;
        int           k;
        logic         saw_done;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; op_s = 1'b0;
        #12;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant vectors
        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0});
`ifdef ADD8_SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif
        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].vo,
                   vecs[i].er, vecs[i].ec, vecs[i].ev);
        end

        // Randomized operations against the model
        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = (n % 3 == 0) ? ~ra : W'($urandom);
            rc = 1'($urandom_range(0, 1));
            ro = 1'b0;
`ifdef ADD8_SUB_EN
            ro = 1'($urandom_range(0, 1));
`endif
            model(ra, rb, rc, ro, er, ec, ev);
            run_op(ra, rb, rc, ro, er, ec, ev);
        end

        // Start held high through BUSY while operands change
        model(32'h01020304, 32'h10203040, 1'b1, 1'b0, er, ec, ev);
        a = 32'h01020304; b = 32'h10203040; cin = 1'b1; op_s = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (k < 3*NB) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            @(posedge clk); #1; k++;
            if (done) break;
            check("held_busy_ready", ready, 0);
        end
        start = 1'b0;
        check("held_latency", k, NB);
        check("held_result", result, er);
        check("held_cout", cout, ec);
        $display("held-start op -> result=%h cout=%0d", result, cout);
        @(posedge clk); #1;
        check("held_done_pulse", done, 0);

        // Back-to-back: start during DONE, next done 5 cycles later
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
        model(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0, er, ec, ev);
        a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b0; op_s = 1'b0; start = 1'b1;
        k = 0;
        while (k < 4*NB) begin
            @(posedge clk); #1; start = 1'b0; k++;
            if (done) break;
        end
        check("b2b_spacing", k, NB + 1);
        check("b2b_result", result, er);
        $display("back-to-back op -> spacing=%0d result=%h", k, result);

        // Asynchronous abort mid-operation (idx=2)
        run_op(32'hC0000001, 32'h80000001, 1'b0, 1'b0, 32'h40000002, 1'b1, 1'b1);
        a = 32'h01010101; b = 32'h01010101; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        check("abort_done", done, 0);
        check("abort_ready", ready, 1);
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 3*NB; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        $display("abort sequence -> done_after_abort=%0d", saw_done);
        run_op(32'h00000010, 32'h00000020, 1'b1, 1'b0, 32'h00000031, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
